// File: rtl/lgcb_pkg.sv
// Shared types and default sizing for the lock-gated counter bank.
package lgcb_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SETTLING = 2'd1,
        ST_RUN      = 2'd2
    } lgcb_state_e;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_DIV_W       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_WAIT   = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int lgcb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lgcb_channel.sv
// One counter channel: clock-enable prescaler, up/down wrap/saturate counter
// with clear/load, and a registered terminal-count pulse.
module lgcb_channel #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             flush,
    input  logic [DIV_W-1:0] div,
    input  logic             down,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL1 = '1;

    logic [DIV_W-1:0] presc;
    logic             tick;
    logic [WIDTH-1:0] q_step;

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                    input logic dn,
                                                    input logic st);
        if (dn) begin
            if (cur == '0)
                return st ? '0 : ALL1;
            return cur - WIDTH'(1);
        end
        if (cur == ALL1)
            return st ? ALL1 : '0;
        return cur + WIDTH'(1);
    endfunction

    function automatic logic is_terminal(input logic [WIDTH-1:0] v, input logic dn);
        return dn ? (v == '0) : (v == ALL1);
    endfunction

    assign tick   = active & (presc == div);
    assign q_step = step_count(q, down, sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            q     <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr) begin
                q     <= '0;
                presc <= '0;
            end else if (load) begin
                q <= load_val;
                if (flush)
                    presc <= '0;
            end else begin
                // Leaving RUN always restarts the prescale phase, even if a tick lands now.
                if (flush)
                    presc <= '0;
                else if (active)
                    presc <= tick ? '0 : presc + DIV_W'(1);
                if (tick) begin
                    q  <= q_step;
                    tc <= is_terminal(q_step, down);
                end
            end
        end
    end

endmodule

// File: rtl/lock_gated_counter_bank.sv
// Bank of prescaled counter channels, enabled only after the PLL lock input
// has been synchronised and held high for LOCK_WAIT cycles.
module lock_gated_counter_bank
    import lgcb_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_WAIT   = DEF_LOCK_WAIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lock_in,
    input  logic                      clken,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*DIV_W-1:0] ch_div,
    input  logic [CHANNELS-1:0]       ch_down,
    input  logic [CHANNELS-1:0]       ch_sat,
    input  logic [CHANNELS-1:0]       ch_clr,
    input  logic [CHANNELS-1:0]       ch_load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       tc,
    output logic                      locked
);

    localparam int                 SETTLE_W    = lgcb_cnt_w(LOCK_WAIT);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_WAIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_sync;
    lgcb_state_e            state;
    logic [SETTLE_W-1:0]    settle;
    logic                   run_en;
    logic                   leave_run;

    assign lock_sync = sync_q[SYNC_STAGES-1];
    assign leave_run = (state == ST_RUN) & ~lock_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
    end

    // locked and run_en are set on the same edge that enters or stays in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_UNLOCKED;
            settle <= '0;
            locked <= 1'b0;
            run_en <= 1'b0;
        end else begin
            locked <= 1'b0;
            run_en <= 1'b0;
            case (state)
                ST_UNLOCKED: begin
                    settle <= '0;
                    if (lock_sync)
                        state <= ST_SETTLING;
                end
                ST_SETTLING: begin
                    settle <= settle + SETTLE_W'(1);
                    if (!lock_sync) begin
                        state <= ST_UNLOCKED;
                    end else if (settle == SETTLE_LAST) begin
                        state  <= ST_RUN;
                        locked <= 1'b1;
                        run_en <= clken;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync) begin
                        state <= ST_UNLOCKED;
                    end else begin
                        locked <= 1'b1;
                        run_en <= clken;
                    end
                end
                default: state <= ST_UNLOCKED;
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        lgcb_channel #(
            .WIDTH (WIDTH),
            .DIV_W (DIV_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .active   (run_en & ch_en[i]),
            .flush    (leave_run),
            .div      (ch_div[i*DIV_W +: DIV_W]),
            .down     (ch_down[i]),
            .sat      (ch_sat[i]),
            .clr      (ch_clr[i]),
            .load     (ch_load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .q        (q[i*WIDTH +: WIDTH]),
            .tc       (tc[i])
        );
    end

endmodule

// File: tb/tb_lock_gated_counter_bank.sv
// Directed bench for lock_gated_counter_bank at default parameters.
module tb_lock_gated_counter_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_in = 1'b0;
    logic       clken = 1'b0;
    logic [1:0] ch_en = '0;
    logic [7:0] ch_div = '0;
    logic [1:0] ch_down = '0;
    logic [1:0] ch_sat = '0;
    logic [1:0] ch_clr = '0;
    logic [1:0] ch_load = '0;
    logic [7:0] load_val = '0;
    logic [7:0] q;
    logic [1:0] tc;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    lock_gated_counter_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lock_in  (lock_in),
        .clken    (clken),
        .ch_en    (ch_en),
        .ch_div   (ch_div),
        .ch_down  (ch_down),
        .ch_sat   (ch_sat),
        .ch_clr   (ch_clr),
        .ch_load  (ch_load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Reset for one edge, then release with the given lock level; the next edge is edge 1.
    task automatic reset_dut(input logic lk);
        rst_n = 1'b0;
        step();
        lock_in = lk;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    logic [3:0] dsat_q [5] = '{4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
    logic       dsat_tc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        step();
        step();
        chk("rst_q", q, 8'h00);
        chk("rst_tc", tc, 2'b00);
        chk("rst_locked", locked, 1'b0);

        // Lock-up: locked on edge 7, counting from edge 8
        clken = 1'b1;
        ch_en = 2'b11;
        ch_div = 8'h00;
        reset_dut(1'b1);
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("lockup_locked", locked, (e >= 7) ? 1 : 0);
            chk("lockup_q0", q[3:0], (e >= 8) ? e - 7 : 0);
        end
        chk("lockup_q1", q[7:4], 4'h3);

        // Glitch: three-cycle lock pulse never reaches RUN
        reset_dut(1'b0);
        lock_in = 1'b1;
        step();
        step();
        step();
        lock_in = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("glitch_locked", locked, 1'b0);
            chk("glitch_q0", q[3:0], 4'h0);
        end
        ch_load = 2'b01;
        load_val = 8'h05;
        step();
        chk("unlocked_load_q0", q[3:0], 4'h5);
        chk("unlocked_load_tc0", tc[0], 1'b0);
        ch_load = 2'b00;
        ch_clr = 2'b01;
        step();
        chk("unlocked_clr_q0", q[3:0], 4'h0);
        ch_clr = 2'b00;

        // Prescale by 3 with wrap: q0 = k on edge 7+3k, tc0 only after the F tick
        ch_en = 2'b01;
        ch_div = 8'h02;
        reset_dut(1'b1);
        for (int e = 1; e <= 56; e++) begin
            step();
            chk("presc_q0", q[3:0], (e < 10) ? 0 : ((e - 7) / 3) % 16);
            chk("presc_tc0", tc[0], (e == 52) ? 1 : 0);
        end
        chk("presc_q1_idle", q[7:4], 4'h0);

        // Down-saturate on channel 1 from a load of 3
        ch_en = 2'b10;
        ch_down = 2'b10;
        ch_sat = 2'b10;
        load_val = 8'h30;
        ch_load = 2'b10;
        step();
        chk("dsat_load_q1", q[7:4], 4'h3);
        chk("dsat_load_tc1", tc[1], 1'b0);
        ch_load = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("dsat_q1", q[7:4], dsat_q[k]);
            chk("dsat_tc1", tc[1], dsat_tc[k]);
        end
        ch_down = 2'b00;
        ch_sat = 2'b00;

        // Lock loss with q0=5, presc0=1, then relock
        ch_en = 2'b01;
        ch_div = 8'h02;
        reset_dut(1'b1);
        run_to(23);
        chk("loss_pre_q0", q[3:0], 4'h5);
        chk("loss_pre_locked", locked, 1'b1);
        lock_in = 1'b0;
        step();
        chk("loss_e24_q0", q[3:0], 4'h5);
        chk("loss_e24_locked", locked, 1'b1);
        step();
        chk("loss_e25_q0", q[3:0], 4'h6);
        chk("loss_e25_locked", locked, 1'b1);
        step();
        chk("loss_e26_q0", q[3:0], 4'h6);
        chk("loss_e26_locked", locked, 1'b0);
        run_to(30);
        chk("loss_hold_q0", q[3:0], 4'h6);
        chk("loss_hold_locked", locked, 1'b0);
        lock_in = 1'b1;
        run_to(36);
        chk("relock_e36_locked", locked, 1'b0);
        step();
        chk("relock_e37_locked", locked, 1'b1);
        chk("relock_e37_q0", q[3:0], 4'h6);
        run_to(39);
        chk("relock_e39_q0", q[3:0], 4'h6);
        step();
        chk("relock_e40_q0", q[3:0], 4'h7);

        // Priority: clr > load > tick, and load suppresses tc
        ch_div = 8'h00;
        step();
        chk("prio_tick_q0", q[3:0], 4'h8);
        ch_clr = 2'b01;
        ch_load = 2'b01;
        load_val = 8'h09;
        step();
        chk("prio_clr_q0", q[3:0], 4'h0);
        chk("prio_clr_tc0", tc[0], 1'b0);
        ch_clr = 2'b00;
        step();
        chk("prio_load_q0", q[3:0], 4'h9);
        chk("prio_load_tc0", tc[0], 1'b0);
        ch_load = 2'b00;
        step();
        chk("prio_after_q0", q[3:0], 4'hA);
        ch_load = 2'b01;
        load_val = 8'h0E;
        step();
        chk("prio_loadE_q0", q[3:0], 4'hE);
        chk("prio_loadE_tc0", tc[0], 1'b0);
        ch_load = 2'b00;
        step();
        chk("up_term_q0", q[3:0], 4'hF);
        chk("up_term_tc0", tc[0], 1'b1);
        ch_sat = 2'b01;
        ch_clr = 2'b01;
        ch_load = 2'b01;
        load_val = 8'h09;
        step();
        chk("prio_clrsat_q0", q[3:0], 4'h0);
        chk("prio_clrsat_tc0", tc[0], 1'b0);
        ch_clr = 2'b00;
        step();
        chk("prio_load9_q0", q[3:0], 4'h9);
        load_val = 8'h0F;
        step();
        chk("usat_load_q0", q[3:0], 4'hF);
        chk("usat_load_tc0", tc[0], 1'b0);
        ch_load = 2'b00;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("usat_q0", q[3:0], 4'hF);
            chk("usat_tc0", tc[0], 1'b1);
        end

        // Asynchronous reset mid-cycle from a non-zero state
        rst_n = 1'b0;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_tc", tc, 2'b00);
        chk("arst_locked", locked, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
